alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter.sv | 138 +++++++++++++
 tb/tb_alu_iter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: valid/ready ALU; single-cycle ops finish in one cycle, MUL uses an iterative shift-add.
// Define ALU_ITER_MUL_EN to build in the multiplier; without it opcode 110 behaves as reserved.
module alu_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALUCtrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic [3:0]       ALUFlags
);
   typedef enum logic [1:0] {
      IDLE,
`ifdef ALU_ITER_MUL_EN
      MUL,
`endif
      DONE
   } state_t;

   state_t state, state_nx;

   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] comb_res;
   logic             comb_v;
   logic             comb_c;
   logic             accept;

   assign accept = (state == IDLE) && in_valid;

   // Single-cycle datapath works on the live inputs; its result is registered at accept.
   always_comb begin
      is_sub   = (ALUCtrl == 3'b001);
      b_eff    = is_sub ? ~B : B;
      sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      comb_res = '0;
      comb_v   = 1'b0;
      comb_c   = 1'b0;
      case (ALUCtrl)
         3'b000, 3'b001: begin
            comb_res = sum[WIDTH-1:0];
            comb_c   = sum[WIDTH];
            comb_v   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         3'b010:  comb_res = A & B;
         3'b011:  comb_res = A | B;
         3'b100:  comb_res = A ^ B;
         3'b101:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         default: comb_res = '0;
      endcase
   end

`ifdef ALU_ITER_MUL_EN
   localparam int unsigned CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nx;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               mul_last;

   // The last iteration writes its sum straight to Result so MUL occupies exactly WIDTH cycles.
   assign mul_last = (cnt == CW'(WIDTH - 1));
   assign acc_nx   = mplier[0] ? (acc + mcand) : acc;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
`ifdef ALU_ITER_MUL_EN
            if (in_valid) state_nx = (ALUCtrl == 3'b110) ? MUL : DONE;
`else
            if (in_valid) state_nx = DONE;
`endif
         end
`ifdef ALU_ITER_MUL_EN
         MUL: if (mul_last) state_nx = DONE;
`endif
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Result   <= '0;
         ALUFlags <= '0;
`ifdef ALU_ITER_MUL_EN
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
`endif
      end else if (accept) begin
         Result   <= comb_res;
         ALUFlags <= {comb_v, comb_c, comb_res[WIDTH-1], (comb_res == '0)};
`ifdef ALU_ITER_MUL_EN
         acc      <= '0;
         mcand    <= {{WIDTH{1'b0}}, A};
         mplier   <= B;
         cnt      <= '0;
`endif
      end
`ifdef ALU_ITER_MUL_EN
      else if (state == MUL) begin
         acc    <= acc_nx;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (mul_last) begin
            Result   <= acc_nx[WIDTH-1:0];
            ALUFlags <= {1'b0, (acc_nx[2*WIDTH-1:WIDTH] != '0), acc_nx[WIDTH-1],
                         (acc_nx[WIDTH-1:0] == '0)};
         end
      end
`endif
   end
endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (WIDTH=32): directed table, reset sequences, random vs. model.
module tb_alu_iter;
   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALUCtrl;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Result;
   logic [3:0]  ALUFlags;

   int unsigned checks = 0;
   int unsigned errors = 0;

`ifdef ALU_ITER_MUL_EN
   localparam int unsigned MUL_LAT = 33;
   localparam bit          MUL_ON  = 1'b1;
`else
   localparam int unsigned MUL_LAT = 1;
   localparam bit          MUL_ON  = 1'b0;
`endif

   alu_iter #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .ALUCtrl(ALUCtrl), .out_valid(out_valid), .out_ready(out_ready),
      .Result(Result), .ALUFlags(ALUFlags)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on 64-bit values, returns {flags[3:0], result[31:0]}.
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint          s;
      longint unsigned u;
      logic [31:0]     r = '0;
      logic            v = 1'b0;
      logic            c = 1'b0;
      case (op)
         3'd0: begin
            u = 64'(a) + 64'(b); r = u[31:0]; c = u[32];
            s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd1: begin
            r = a - b; c = (a >= b);
            s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
         3'd6: if (MUL_ON) begin
            u = 64'(a) * 64'(b); r = u[31:0]; c = (u[63:32] != 0);
         end
         default: r = '0;
      endcase
      return {v, c, r[31], (r == 0), r};
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] er, input logic [3:0] ef, input int unsigned el,
                         input int unsigned hold, input string name);
      int unsigned n = 0;
      int unsigned lat = 1;
      bit          busy_ready = 1'b0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, " in_ready idle"}, in_ready, 1);
      A = a; B = b; ALUCtrl = op; in_valid = 1'b1;
      @(posedge clk); #1;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ready = 1'b1;
         A = $urandom; B = $urandom; ALUCtrl = 3'($urandom);
         out_ready = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      out_ready = 1'b0;
      A = $urandom; B = $urandom; ALUCtrl = 3'($urandom);
      check({name, " latency"}, lat, el);
      check({name, " in_ready busy"}, busy_ready, 0);
      check({name, " result"}, Result, er);
      check({name, " flags"}, ALUFlags, ef);
      for (int unsigned h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         A = $urandom; B = $urandom;
         check({name, " hold valid"}, out_valid, 1);
         check({name, " hold in_ready"}, in_ready, 0);
         check({name, " hold result"}, Result, er);
         check({name, " hold flags"}, ALUFlags, ef);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({name, " post in_ready"}, in_ready, 1);
      check({name, " post valid"}, out_valid, 0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [31:0] res;
      logic [3:0]  flg;
      int unsigned lat;
      int unsigned hold;
      string       name;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [35:0] m;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rop;

      vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 3'd0, 32'h80000000, 4'b1010, 1, 0, "add_ovf"});
      vecs.push_back('{32'h12345678, 32'h12345678, 3'd1, 32'h00000000, 4'b0101, 1, 5, "sub_eq_bp"});
      vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 3'd5, 32'h00000001, 4'b0000, 1, 0, "slt_neg"});
      vecs.push_back('{32'h00000000, 32'h00000001, 3'd1, 32'hFFFFFFFF, 4'b0010, 1, 1, "sub_borrow"});
      vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 3'd0, 32'h00000000, 4'b0101, 1, 0, "add_carry"});
      vecs.push_back('{32'h80000000, 32'h00000001, 3'd1, 32'h7FFFFFFF, 4'b1100, 1, 0, "sub_ovf"});
      vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 3'd2, 32'hF000F000, 4'b0010, 1, 0, "and"});
      vecs.push_back('{32'h00000000, 32'h00000000, 3'd3, 32'h00000000, 4'b0001, 1, 0, "or_zero"});
      vecs.push_back('{32'h0F0F0F0F, 32'hF0F0F0F0, 3'd4, 32'hFFFFFFFF, 4'b0010, 1, 0, "xor"});
      vecs.push_back('{32'h00000001, 32'hFFFFFFFF, 3'd5, 32'h00000000, 4'b0001, 1, 0, "slt_false"});
      vecs.push_back('{32'h00000005, 32'h00000006, 3'd7, 32'h00000000, 4'b0001, 1, 0, "reserved"});
`ifdef ALU_ITER_MUL_EN
      vecs.push_back('{32'h00010000, 32'h00010001, 3'd6, 32'h00010000, 4'b0100, 33, 2, "mul_hi"});
      vecs.push_back('{32'h00000003, 32'h00000005, 3'd6, 32'h0000000F, 4'b0000, 33, 0, "mul_small"});
`else
      vecs.push_back('{32'h00000003, 32'h00000005, 3'd6, 32'h00000000, 4'b0001, 1, 0, "mul_off"});
      vecs.push_back('{32'h00010000, 32'h00010001, 3'd6, 32'h00000000, 4'b0001, 1, 0, "mul_off_hi"});
`endif

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; ALUCtrl = '0;
      #1;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset result", Result, 0);
      check("reset flags", ALUFlags, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i])
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flg,
                vecs[i].lat, vecs[i].hold, vecs[i].name);

      // Reset while holding a result in DONE, then accept on the first edge after release.
      @(negedge clk);
      A = 32'h7FFFFFFF; B = 32'h1; ALUCtrl = 3'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("done_rst pre valid", out_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("done_rst valid", out_valid, 0);
      check("done_rst result", Result, 0);
      check("done_rst flags", ALUFlags, 0);
      check("done_rst in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0; A = 32'd3; B = 32'd4; ALUCtrl = 3'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("first_after_rst valid", out_valid, 1);
      check("first_after_rst result", Result, 7);
      check("first_after_rst flags", ALUFlags, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("first_after_rst release", in_ready, 1);

`ifdef ALU_ITER_MUL_EN
      @(negedge clk);
      A = 32'h00010000; B = 32'h00010001; ALUCtrl = 3'd6; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("mul_rst valid", out_valid, 0);
      check("mul_rst result", Result, 0);
      check("mul_rst flags", ALUFlags, 0);
      check("mul_rst in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("mul_rst discarded", out_valid, 0);
`endif
      run_op(32'd3, 32'd4, 3'd0, 32'd7, 4'b0000, 1, 0, "add_after_rst");

      for (int i = 0; i < 150; i++) begin
         ra  = $urandom;
         rb  = (i % 5 == 0) ? ra : 32'($urandom);
         rop = 3'($urandom_range(0, 7));
         m   = model(ra, rb, rop);
         run_op(ra, rb, rop, m[31:0], m[35:32], (rop == 3'd6) ? MUL_LAT : 1,
                $urandom_range(0, 2), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
